// File: rtl/distribute_switch_ctrl_pkg.sv
// distribute_switch_ctrl_pkg: destination encoding and FSM states shared by the controller and switch benches
package distribute_switch_ctrl_pkg;
  localparam logic [1:0] DEST_DRAIN = 2'b00;
  localparam logic [1:0] DEST_LOW   = 2'b01;
  localparam logic [1:0] DEST_HIGH  = 2'b10;
  localparam logic [1:0] DEST_DUP   = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/distribute_switch_ctrl_sync_fifo.sv
// sync_fifo: command queue with wrap bit on each pointer to tell full from empty
module sync_fifo
  import distribute_switch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];
  // pointer advance; a push while full is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/distribute_switch_ctrl.sv
// distribute_switch_ctrl: sequences queued commands into a one-beat output register feeding a 1-to-2 switch
module distribute_switch_ctrl
  import distribute_switch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_dest,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [DATA_WIDTH-1:0] i_data_bus,
  input  logic [1:0]            i_down_ready,
  output logic                  o_sw_en,
  output logic [1:0]            o_sw_cmd,
  output logic [1:0]            o_sw_valid,
  output logic [DATA_WIDTH-1:0] o_sw_data_bus,
  output logic                  o_busy,
  output logic                  o_done
);
  state_t state;
  logic [1:0] cur_dest, out_dest, q_dest;
  logic [LEN_WIDTH-1:0] cur_len, beat_cnt, q_len;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid, done, full, empty, pop, out_accept, fire;
  assign pop        = (state == IDLE) && !empty;
  assign out_accept = out_valid && (&(i_down_ready | ~out_dest));
  assign o_data_ready = (state == STREAM) && (!out_valid || out_accept);
  assign fire       = i_data_valid && o_data_ready;
  sync_fifo #(.DATA_WIDTH(2 + LEN_WIDTH), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (i_cmd_valid && !full),
    .pop  (pop),
    .din  ({i_cmd_dest, i_cmd_len}),
    .dout ({q_dest, q_len}),
    .full (full),
    .empty(empty)
  );
  // command FSM plus the output beat register; a stalled beat holds until the switch takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_dest  <= DEST_DRAIN;
      cur_len   <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_dest  <= DEST_DRAIN;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= fire || (out_valid && !out_accept);
      if (fire) begin
        out_data <= i_data_bus;
        out_dest <= cur_dest;
      end
      case (state)
        IDLE: if (!empty) begin
          cur_dest <= q_dest;
          cur_len  <= q_len;
          beat_cnt <= '0;
          state    <= (q_len == '0) ? IDLE : STREAM;
          done     <= q_len == '0;
        end
        STREAM: if (fire) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == cur_len - 1'b1) state <= FLUSH;
        end
        FLUSH: if (!out_valid || out_accept) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_cmd_ready   = !full;
  assign o_sw_en       = out_valid;
  assign o_sw_cmd      = out_dest;
  assign o_sw_valid    = out_valid ? out_dest : DEST_DRAIN;
  assign o_sw_data_bus = out_data;
  assign o_busy        = (state != IDLE) || !empty;
  assign o_done        = done;
endmodule

// File: tb/tb_distribute_switch_ctrl.sv
// tb_distribute_switch_ctrl: table vectors, directed corner sequences and a randomized run against a transaction-level scoreboard
module tb_distribute_switch_ctrl;
  localparam int DW = 32;
  localparam int LW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic i_cmd_valid, o_cmd_ready, i_data_valid, o_data_ready, o_sw_en, o_busy, o_done;
  logic [1:0] i_cmd_dest, i_down_ready, o_sw_cmd, o_sw_valid;
  logic [LW-1:0] i_cmd_len;
  logic [DW-1:0] i_data_bus, o_sw_data_bus;
  always #5 clk = ~clk;
  distribute_switch_ctrl #(.DATA_WIDTH(DW), .CMD_DEPTH(4), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_dest(i_cmd_dest), .i_cmd_len(i_cmd_len), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .i_data_bus(i_data_bus), .i_down_ready(i_down_ready),
    .o_sw_en(o_sw_en), .o_sw_cmd(o_sw_cmd), .o_sw_valid(o_sw_valid),
    .o_sw_data_bus(o_sw_data_bus), .o_busy(o_busy), .o_done(o_done)
  );
  typedef struct {logic [1:0] dest; logic [LW-1:0] len;} cmd_t;
  typedef struct {logic [1:0] dest; logic [DW-1:0] data;} beat_t;
  typedef struct {logic [1:0] dest; logic [LW-1:0] len; logic [1:0] down; logic [11:0] en; logic [11:0] dn; int del; logic busy;} vec_t;
  cmd_t cin[$], mq[$];
  logic [DW-1:0] din[$];
  beat_t bq[$];
  vec_t tbl[8];
  int checks = 0, errors = 0, dones, exp_dones, delivered, fed, mode;
  logic gate_c, gate_d, pushed, fired, stalled, last_en, last_done, last_busy;
  logic [1:0] down;
  logic [DW-1:0] held;
  logic [11:0] en_tr, dn_tr;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic apply();
    i_cmd_valid  = (cin.size() > 0) && gate_c;
    i_cmd_dest   = cin.size() > 0 ? cin[0].dest : 2'b00;
    i_cmd_len    = cin.size() > 0 ? cin[0].len : '0;
    i_data_valid = (din.size() > 0) && gate_d;
    i_data_bus   = din.size() > 0 ? din[0] : '0;
    i_down_ready = down;
  endtask
  task automatic observe();
    logic acc;
    beat_t b;
    fired  = i_data_valid && o_data_ready;
    pushed = i_cmd_valid && o_cmd_ready;
    acc    = o_sw_en && (&(i_down_ready | ~o_sw_cmd));
    last_en = o_sw_en; last_done = o_done; last_busy = o_busy;
    if (o_done) dones++;
    if (stalled) chk("stall_hold", o_sw_data_bus, held);
    if (acc) begin
      chk("beat_expected", bq.size() > 0, 1);
      if (bq.size() > 0) begin
        b = bq.pop_front();
        chk("beat_valid", o_sw_valid, b.dest);
        chk("beat_cmd", o_sw_cmd, b.dest);
        chk("beat_data", o_sw_data_bus, b.data);
        delivered++;
      end
    end else if (o_sw_en) chk("stall_no_fire", o_data_ready, 0);
    stalled = o_sw_en && !acc;
    held = o_sw_data_bus;
    if (fired) begin
      chk("fire_expected", mq.size() > 0, 1);
      if (mq.size() > 0) begin
        bq.push_back('{mq[0].dest, i_data_bus});
        fed++;
        if (fed == int'(mq[0].len)) begin
          void'(mq.pop_front());
          fed = 0;
          exp_dones++;
        end
      end
    end
    if (pushed) begin
      if (i_cmd_len == '0) exp_dones++;
      else mq.push_back('{i_cmd_dest, i_cmd_len});
    end
  endtask
  task automatic cyc();
    @(negedge clk); #1 observe();
    @(posedge clk); #1;
    if (pushed) void'(cin.pop_front());
    if (fired) void'(din.pop_front());
    if (mode != 0) begin
      if (mode == 1 && cin.size() < 2 && $urandom_range(3) == 0)
        cin.push_back('{2'($urandom_range(3)), LW'($urandom_range(4))});
      if (din.size() < 3) din.push_back($urandom);
      gate_c = mode == 2 || $urandom_range(1) == 1;
      gate_d = mode == 2 || $urandom_range(3) != 0;
      down   = mode == 2 ? 2'b11 : 2'($urandom_range(3));
    end
    apply();
  endtask
  task automatic clear_model();
    cin.delete(); din.delete(); mq.delete(); bq.delete();
    fed = 0; stalled = 0; dones = 0; exp_dones = 0; delivered = 0; mode = 0;
    gate_c = 1; gate_d = 1; down = 2'b11; pushed = 0; fired = 0;
    apply();
  endtask
  task automatic do_reset();
    rst = 1; clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic check_reset(input string n);
    chk({n, "_cmd_ready"}, o_cmd_ready, 1);
    chk({n, "_data_ready"}, o_data_ready, 0);
    chk({n, "_sw_en"}, o_sw_en, 0);
    chk({n, "_sw_cmd"}, o_sw_cmd, 0);
    chk({n, "_sw_valid"}, o_sw_valid, 0);
    chk({n, "_sw_data"}, o_sw_data_bus, 0);
    chk({n, "_busy"}, o_busy, 0);
    chk({n, "_done"}, o_done, 0);
  endtask
  initial begin
    tbl[0] = '{2'b01, 8'd3, 2'b11, 12'h038, 12'h040, 3, 1'b0};
    tbl[1] = '{2'b10, 8'd1, 2'b11, 12'h008, 12'h010, 1, 1'b0};
    tbl[2] = '{2'b01, 8'd0, 2'b11, 12'h000, 12'h004, 0, 1'b0};
    tbl[3] = '{2'b11, 8'd2, 2'b11, 12'h018, 12'h020, 2, 1'b0};
    tbl[4] = '{2'b00, 8'd2, 2'b00, 12'h018, 12'h020, 2, 1'b0};
    tbl[5] = '{2'b10, 8'd2, 2'b01, 12'hFF8, 12'h000, 0, 1'b1};
    tbl[6] = '{2'b11, 8'd1, 2'b10, 12'hFF8, 12'h000, 0, 1'b1};
    tbl[7] = '{2'b01, 8'd2, 2'b01, 12'h018, 12'h020, 2, 1'b0};
    do_reset();
    check_reset("reset");
    for (int r = 0; r < 8; r++) begin
      do_reset();
      cin.push_back('{tbl[r].dest, tbl[r].len});
      for (int k = 0; k < int'(tbl[r].len); k++) din.push_back($urandom);
      down = tbl[r].down;
      apply();
      for (int k = 0; k < 12; k++) begin
        cyc();
        en_tr[k] = last_en;
        dn_tr[k] = last_done;
      end
      chk($sformatf("row%0d_en_trace", r), en_tr, tbl[r].en);
      chk($sformatf("row%0d_done_trace", r), dn_tr, tbl[r].dn);
      chk($sformatf("row%0d_delivered", r), delivered, tbl[r].del);
      chk($sformatf("row%0d_busy", r), last_busy, tbl[r].busy);
    end
    do_reset();
    cin.push_back('{2'b11, 8'd2});
    din.push_back(32'h5); din.push_back(32'h6);
    down = 2'b01; apply();
    repeat (7) cyc();
    chk("dup_stall_valid", o_sw_valid, 2'b11);
    chk("dup_stall_data", o_sw_data_bus, 32'h5);
    chk("dup_stall_ready", o_data_ready, 0);
    down = 2'b11; apply();
    repeat (8) cyc();
    chk("dup_delivered", delivered, 2);
    chk("dup_dones", dones, 1);
    do_reset();
    cin.push_back('{2'b00, 8'd2}); cin.push_back('{2'b10, 8'd1});
    din.push_back(32'h1); din.push_back(32'h2); din.push_back(32'h3);
    apply();
    repeat (16) cyc();
    chk("drain_high_delivered", delivered, 3);
    chk("drain_high_dones", dones, 2);
    do_reset();
    cin.push_back('{2'b10, 8'd1}); din.push_back(32'h77);
    down = 2'b00; apply();
    repeat (6) cyc();
    for (int k = 0; k < 5; k++) begin
      cin.push_back('{2'b01, 8'd1});
      din.push_back(32'h100 + k);
    end
    apply();
    repeat (6) cyc();
    chk("full_cmd_ready", o_cmd_ready, 0);
    chk("full_pending", cin.size(), 1);
    down = 2'b11; apply();
    repeat (40) cyc();
    chk("full_pending_after", cin.size(), 0);
    chk("full_delivered", delivered, 6);
    chk("full_dones", dones, 6);
    chk("full_busy", o_busy, 0);
    do_reset();
    cin.push_back('{2'b10, 8'd4});
    for (int k = 0; k < 4; k++) din.push_back(32'hA0 + k);
    apply();
    repeat (5) cyc();
    chk("midrst_delivered", delivered, 2);
    rst = 1; clear_model();
    @(posedge clk); #1;
    check_reset("midrst");
    rst = 0;
    repeat (4) cyc();
    chk("midrst_no_done", dones, 0);
    do_reset();
    mode = 1;
    repeat (3000) cyc();
    mode = 2;
    for (int i = 0; i < 500 && (cin.size() > 0 || mq.size() > 0 || bq.size() > 0); i++) cyc();
    repeat (4) cyc();
    chk("rand_cmds_left", mq.size() + cin.size(), 0);
    chk("rand_beats_left", bq.size(), 0);
    chk("rand_dones", dones, exp_dones);
    chk("rand_busy", o_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
